// File: rtl/w4823_fir_pkg.sv
// w4823_fir_pkg: state encoding and framing constants shared by the FIR coefficient loader
package w4823_fir_pkg;
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;
    localparam int BYTES_PER_COEF = 3;
    localparam logic [7:0] CHECK_OK = 8'h00;
endpackage

// File: rtl/fir_coef_byte_timer.sv
// fir_coef_byte_timer: inter-byte watchdog; expires after TIMEOUT-1 enabled cycles without a clear
module fir_coef_byte_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] cnt;

    assign expired = en && cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk_fast or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: packs a host byte stream into CMEM coefficient writes for W4823_FIR,
// validating each frame with an 8-bit checksum, reserved-bit check and per-byte timeout
module fir_coef_loader
    import w4823_fir_pkg::*;
#(
    parameter int NCOEF   = 64,
    parameter int AW      = 6,
    parameter int CW      = 17,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic [AW-1:0] caddr,
    output logic [CW-1:0] cin,
    output logic          cload,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [1:0]    B_LAST = 2'(BYTES_PER_COEF - 1);
    localparam logic [AW-1:0] A_LAST = AW'(NCOEF - 1);

    state_t        state, nxt;
    logic [1:0]    bidx;
    logic [AW-1:0] addr;
    logic [7:0]    sum, sum_nxt;
    logic [15:0]   lo;
    logic          rsv_err, take, expired;

    assign byte_ready = state == RECV || state == CHECK;
    // a byte arriving on the timeout edge is dropped
    assign take    = byte_valid && byte_ready && !expired;
    assign sum_nxt = sum + byte_in;

    fir_coef_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_fast(clk_fast),
        .rst_n   (rst_n),
        .clr     (!byte_ready || take),
        .en      (byte_ready),
        .expired (expired)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start && !abort ? RECV : IDLE;
            RECV:    nxt = expired ? ERR : (take && bidx == B_LAST) ? WRITE : RECV;
            WRITE:   nxt = addr == A_LAST ? CHECK : RECV;
            CHECK:   nxt = expired ? ERR : !take ? CHECK
                         : (sum_nxt == CHECK_OK && !rsv_err) ? DONE : ERR;
            DONE:    nxt = IDLE;
            ERR:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE)
            nxt = ERR;
    end

    always_ff @(posedge clk_fast or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            bidx    <= '0;
            addr    <= '0;
            sum     <= '0;
            lo      <= '0;
            rsv_err <= 1'b0;
            caddr   <= '0;
            cin     <= '0;
            cload   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= nxt inside {RECV, WRITE, CHECK};
            done  <= nxt == DONE;
            cload <= nxt == WRITE;
            if (state == IDLE && nxt == RECV) begin
                bidx    <= '0;
                addr    <= '0;
                sum     <= '0;
                rsv_err <= 1'b0;
                err     <= 1'b0;
            end
            if (nxt == ERR)
                err <= 1'b1;
            if (state == RECV && take) begin
                sum  <= sum_nxt;
                bidx <= bidx == B_LAST ? 2'd0 : bidx + 2'd1;
                if (bidx == 2'd0)
                    lo[7:0] <= byte_in;
                if (bidx == 2'd1)
                    lo[15:8] <= byte_in;
                if (bidx == B_LAST)
                    rsv_err <= rsv_err | (|byte_in[7:1]);
            end
            // write address/data are captured with the third byte and held until the next write
            if (nxt == WRITE) begin
                caddr <= addr;
                cin   <= CW'({byte_in[0], lo});
            end
            if (state == WRITE && addr != A_LAST)
                addr <= addr + 1'b1;
        end
endmodule
